// File: rtl/delay_pipe_pkg.sv
// delay_pipe_pkg
// Shared definitions for the variable-latency delay pipe.
//   clog2_dw(depth)          : bits needed to hold a delay/occupancy of 0..depth
//   DELAY_PIPE_MAX_SUPPORTED : largest MAX_DEPTH the pipe is intended for
package delay_pipe_pkg;

  localparam int DELAY_PIPE_MAX_SUPPORTED = 64;

  function automatic int clog2_dw(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/delay_pipe_stage.sv
// delay_pipe_stage
// One {valid, data} stage of the delay pipe.
// Ports:
//   clk, rst   : clock, async active-high reset (clears valid and data)
//   en         : global write enable; when low the stage holds
//   clr_valid  : drops the incoming valid bit (data still shifts)
//   d_valid    : valid bit from the previous stage
//   d_data     : payload from the previous stage
//   q_valid    : registered valid bit
//   q_data     : registered payload
module delay_pipe_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr_valid,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_data  <= '0;
    end else if (en) begin
      q_valid <= d_valid & ~clr_valid;
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/delay_pipe_var.sv
// delay_pipe_var
// Delays a WIDTH-bit payload plus valid by a run-time selectable number of
// cycles (0..MAX_DEPTH). Used to match latency between cache datapath stages.
// Optional feature macro: DELAY_PIPE_OCC_EN adds the occ output.
// Ports:
//   clk, rst   : clock, async active-high reset
//   gwe        : global write enable; 0 freezes every register
//   in_valid   : qualifies in_value
//   in_value   : payload input
//   flush      : clears all in-flight valid bits (incoming item included)
//   cfg_we     : load cfg_delay into cur_delay
//   cfg_delay  : requested delay, saturated to MAX_DEPTH
//   cur_delay  : active delay register
//   out_valid  : delayed valid
//   out_value  : delayed payload (raw stage data when out_valid=0)
//   occ        : valid items in stages 1..cur_delay (DELAY_PIPE_OCC_EN only)
module delay_pipe_var
  import delay_pipe_pkg::*;
#(
  parameter  int WIDTH       = 16,
  parameter  int MAX_DEPTH   = 8,
  parameter  int RESET_DELAY = 8,
  localparam int DW          = clog2_dw(MAX_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gwe,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_value,
  input  logic             flush,
  input  logic             cfg_we,
  input  logic [DW-1:0]    cfg_delay,
  output logic [DW-1:0]    cur_delay,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_value
`ifdef DELAY_PIPE_OCC_EN
  ,
  output logic [DW-1:0]    occ
`endif
);

  if (MAX_DEPTH < 1 || MAX_DEPTH > DELAY_PIPE_MAX_SUPPORTED || RESET_DELAY > MAX_DEPTH) begin : g_bad_param
    $error("delay_pipe_var: illegal MAX_DEPTH/RESET_DELAY combination");
  end

  localparam logic [DW-1:0] MAX_D = DW'(MAX_DEPTH);
  localparam logic [DW-1:0] RST_D = DW'(RESET_DELAY);

  logic [DW-1:0]    cfg_clamped;
  logic             flush_eff;
  logic [MAX_DEPTH:0] v_chain;
  logic [WIDTH-1:0] d_chain [0:MAX_DEPTH];

  assign cfg_clamped = (cfg_delay > MAX_D) ? MAX_D : cfg_delay;
  // A real change of tap position flushes so items are never duplicated or
  // reordered; rewriting the active value leaves the stream untouched.
  assign flush_eff   = flush | (cfg_we & (cfg_clamped != cur_delay));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_delay <= RST_D;
    end else if (gwe && cfg_we) begin
      cur_delay <= cfg_clamped;
    end
  end

  assign v_chain[0] = in_valid;
  assign d_chain[0] = in_value;

  for (genvar k = 1; k <= MAX_DEPTH; k++) begin : g_stage
    delay_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (gwe),
      .clr_valid (flush_eff),
      .d_valid   (v_chain[k-1]),
      .d_data    (d_chain[k-1]),
      .q_valid   (v_chain[k]),
      .q_data    (d_chain[k])
    );
  end

  // Delay 0 is a pure combinational bypass of the input.
  always_comb begin
    out_valid = in_valid;
    out_value = in_value;
    for (int k = 1; k <= MAX_DEPTH; k++) begin
      if (cur_delay == DW'(k)) begin
        out_valid = v_chain[k];
        out_value = d_chain[k];
      end
    end
  end

`ifdef DELAY_PIPE_OCC_EN
  always_comb begin
    occ = '0;
    for (int k = 1; k <= MAX_DEPTH; k++) begin
      if (DW'(k) <= cur_delay) begin
        occ = occ + DW'(v_chain[k]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_delay_pipe_var.sv
// tb_delay_pipe_var
// Directed bench for delay_pipe_var with default parameters
// (WIDTH=16, MAX_DEPTH=8, RESET_DELAY=8). occ is checked only when the
// design is built with DELAY_PIPE_OCC_EN.
module tb_delay_pipe_var;

  logic        clk = 1'b0;
  logic        rst;
  logic        gwe;
  logic        in_valid;
  logic [15:0] in_value;
  logic        flush;
  logic        cfg_we;
  logic [3:0]  cfg_delay;
  logic [3:0]  cur_delay;
  logic        out_valid;
  logic [15:0] out_value;
`ifdef DELAY_PIPE_OCC_EN
  logic [3:0]  occ;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  delay_pipe_var #(.WIDTH(16), .MAX_DEPTH(8), .RESET_DELAY(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .gwe       (gwe),
    .in_valid  (in_valid),
    .in_value  (in_value),
    .flush     (flush),
    .cfg_we    (cfg_we),
    .cfg_delay (cfg_delay),
    .cur_delay (cur_delay),
    .out_valid (out_valid),
    .out_value (out_value)
`ifdef DELAY_PIPE_OCC_EN
    ,
    .occ       (occ)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        g;
    logic        iv;
    logic [15:0] val;
    logic        fl;
    logic        cw;
    logic [3:0]  cd;
    logic [3:0]  exp_cur;
    logic        exp_v;
    logic [15:0] exp_val;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input logic g, input logic iv, input logic [15:0] val,
                              input logic fl, input logic cw, input logic [3:0] cd,
                              input logic [3:0] exp_cur, input logic exp_v,
                              input logic [15:0] exp_val);
    vec_t r;
    r.g = g; r.iv = iv; r.val = val; r.fl = fl; r.cw = cw; r.cd = cd;
    r.exp_cur = exp_cur; r.exp_v = exp_v; r.exp_val = exp_val;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic g, input logic iv, input logic [15:0] v,
                       input logic fl, input logic cw, input logic [3:0] cd);
    gwe = g; in_valid = iv; in_value = v; flush = fl; cfg_we = cw; cfg_delay = cd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic ev;
    int   e;
    int   eo;

    // Rows start with cur_delay=3 and an empty pipe.
    tbl.push_back(mk(1, 0, 16'h0000, 0, 1,  0, 3, 0, 16'h0000)); // r0 set delay 0
    tbl.push_back(mk(1, 1, 16'h5A5A, 0, 0,  0, 0, 1, 16'h5A5A)); // r1 bypass
    tbl.push_back(mk(1, 0, 16'h1111, 0, 0,  0, 0, 0, 16'h0000)); // r2
    tbl.push_back(mk(1, 1, 16'hBEEF, 0, 0,  0, 0, 1, 16'hBEEF)); // r3
    tbl.push_back(mk(0, 1, 16'hC0DE, 0, 1,  5, 0, 1, 16'hC0DE)); // r4 stalled cfg ignored
    tbl.push_back(mk(1, 0, 16'h0000, 0, 1, 15, 0, 0, 16'h0000)); // r5 saturate to 8, flush
    for (int i = 6; i <= 14; i++)
      tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 8, 0, 16'h0000)); // 5A5A/BEEF must not emerge
    tbl.push_back(mk(1, 1, 16'h0101, 0, 0,  0, 8, 0, 16'h0000)); // r15
    tbl.push_back(mk(1, 1, 16'h0202, 0, 1, 15, 8, 0, 16'h0000)); // r16 same value, no flush
    tbl.push_back(mk(1, 1, 16'h0303, 0, 1,  8, 8, 0, 16'h0000)); // r17 same value, no flush
    for (int i = 18; i <= 22; i++)
      tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 8, 0, 16'h0000));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0,  0, 8, 1, 16'h0101)); // r23
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0,  0, 8, 1, 16'h0202)); // r24
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0,  0, 8, 1, 16'h0303)); // r25
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0,  0, 8, 0, 16'h0000)); // r26

    // Reset
    rst = 1'b1;
    drive(1, 0, 16'h0000, 0, 0, 0);
    @(negedge clk);
    check("reset_cur_delay", cur_delay, 8);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_value", out_value, 0);
`ifdef DELAY_PIPE_OCC_EN
    check("reset_occ", occ, 0);
`endif
    #2 rst = 1'b0;
    tick();

    // Stream 1..20 at delay 8
    for (int c = 0; c < 30; c++) begin
      drive(1, c < 20, (c < 20) ? 16'(c + 1) : 16'h0000, 0, 0, 0);
      @(negedge clk);
      ev = (c >= 8 && c < 28);
      check("stream_valid", out_valid, ev);
      if (ev) check("stream_value", out_value, c - 7);
`ifdef DELAY_PIPE_OCC_EN
      eo = 0;
      for (int j = c - 8; j < c; j++) if (j >= 0 && j < 20) eo++;
      check("stream_occ", occ, eo);
`endif
      tick();
    end

    // Same stream with gwe=0 during cycles 4..6; upstream holds its item.
    // e counts enabled edges so far; the item at stage 8 is number e-7.
    e = 0;
    for (int c = 0; c < 32; c++) begin
      logic g;
      g = !(c >= 4 && c <= 6);
      drive(g, e < 20, (e < 20) ? 16'(e + 1) : 16'h0000, 0, 0, 0);
      @(negedge clk);
      ev = (e - 7 >= 1 && e - 7 <= 20);
      check("stall_valid", out_valid, ev);
      if (ev) check("stall_value", out_value, e - 7);
      if (c == 11) check("stall_first_at_11", {out_valid, out_value}, {1'b1, 16'd1});
      tick();
      if (g) e++;
    end

    // Mid-stream change to delay 3
    for (int c = 0; c < 5; c++) begin
      drive(1, 1, 16'h0010 + 16'(c), 0, 0, 0);
      @(negedge clk);
      check("cfg3_pre_valid", out_valid, 0);
      tick();
    end
    drive(1, 0, 16'h0000, 0, 1, 3);
    @(negedge clk);
    check("cfg3_cur_before", cur_delay, 8);
    tick();
    for (int c = 6; c <= 12; c++) begin
      drive(1, c == 6, (c == 6) ? 16'h00AA : 16'h0000, 0, 0, 0);
      @(negedge clk);
      check("cfg3_cur", cur_delay, 3);
      check("cfg3_valid", out_valid, c == 9);
      if (c == 9) check("cfg3_value", out_value, 16'h00AA);
      tick();
    end

    // Table: delay 0 bypass, stalled cfg, saturation, same-value rewrite
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].g, tbl[i].iv, tbl[i].val, tbl[i].fl, tbl[i].cw, tbl[i].cd);
      @(negedge clk);
      check($sformatf("tbl%0d_cur", i), cur_delay, tbl[i].exp_cur);
      check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].exp_v);
      if (tbl[i].exp_v) check($sformatf("tbl%0d_value", i), out_value, tbl[i].exp_val);
      tick();
    end

    // Flush with an incoming item while five are in flight (delay 8)
    for (int c = 0; c <= 17; c++) begin
      if (c < 5)       drive(1, 1, 16'h0021 + 16'(c), 0, 0, 0);
      else if (c == 5) drive(1, 1, 16'h1234, 1, 0, 0);
      else             drive(1, 0, 16'h0000, 0, 0, 0);
      @(negedge clk);
      check("flush_valid", out_valid, 0);
`ifdef DELAY_PIPE_OCC_EN
      if (c <= 5) check("flush_occ_pre", occ, c);
      if (c == 6) check("flush_occ_post", occ, 0);
`endif
      tick();
    end

    // Async reset between edges, with delay 3 active
    drive(1, 0, 16'h0000, 0, 1, 3);
    @(negedge clk);
    check("arst_cur_pre", cur_delay, 8);
    tick();
    for (int c = 1; c <= 4; c++) begin
      drive(1, 1, 16'h0030 + 16'(c), 0, 0, 0);
      @(negedge clk);
      check("arst_stream_valid", out_valid, c == 4);
      if (c == 4) check("arst_stream_value", out_value, 16'h0031);
      if (c < 4) tick();
    end
    #2 rst = 1'b1;
    #1;
    check("arst_cur_delay", cur_delay, 8);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_value", out_value, 0);
    #1 rst = 1'b0;
    tick();
    drive(1, 0, 16'h0000, 0, 0, 0);
    @(negedge clk);
    check("arst_after_cur", cur_delay, 8);
    check("arst_after_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/delay_pipe_var.md
Name: delay_pipe_var

Overview:
- Parametrised successor to the fixed eight-stage delay line.
- Delays a WIDTH-bit payload plus a valid bit by a run-time selectable number of cycles, from 0 to MAX_DEPTH.
- Adds flush, a global stall (gwe) and a registered delay configuration.
- Used for pipeline-latency matching between cache datapath stages, e.g. aligning tag-lookup results with data-array output.

Parameters:
- WIDTH, 16, payload width in bits.
- MAX_DEPTH, 8, number of physical stages; must be >= 1.
- RESET_DELAY, 8, value of cur_delay after reset; must be <= MAX_DEPTH.
- DW (derived, not overridable): $clog2(MAX_DEPTH+1), width of delay and occupancy fields.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- gwe  in  1  global write enable; 0 freezes all state, including config.
- in_valid  in  1  qualifies in_value.
- in_value  in  WIDTH  payload input.
- flush  in  1  clears all in-flight valid bits.
- cfg_we  in  1  load new delay.
- cfg_delay  in  DW  requested delay in cycles.
- cur_delay  out  DW  active delay register.
- out_valid  out  1  delayed valid.
- out_value  out  WIDTH  delayed payload.
- occ  out  DW  in-flight valid count; present only with DELAY_PIPE_OCC_EN.

Behaviour:
- Reset (async, rst=1):
  - All stage data regs = 0 and all stage valid bits = 0.
  - cur_delay = RESET_DELAY.
  - Hence out_valid=0 and out_value=0, except when RESET_DELAY=0, in which case the outputs follow the inputs.
- Stages: stage[1..MAX_DEPTH], each holding {valid, data}.
- Shift on a rising edge with gwe=1:
  - stage[1] <= {in_valid & ~flush_eff, in_value}.
  - stage[k] <= {stage[k-1].valid & ~flush_eff, stage[k-1].data} for k > 1.
  - Data always shifts; only the valid bits are cleared.
- Output tap:
  - cur_delay=0: out_valid=in_valid and out_value=in_value, combinationally, with zero latency.
  - cur_delay=d>0: outputs = stage[d]. Item presented at edge N appears during cycle N+d, counted in gwe=1 edges.
- gwe=0:
  - No register changes; flush and cfg_we are ignored.
  - Outputs hold (delay 0 still passes through combinationally).
  - Latency in wall-clock cycles grows by the number of stalled edges.
- Config (cfg_we=1 and gwe=1):
  - cur_delay <= min(cfg_delay, MAX_DEPTH); saturating, no error flag.
  - The new tap is active from the next cycle.
- flush_eff = flush | (cfg_we & (clamped cfg_delay != cur_delay)).
  - A delay change implicitly flushes, so items are never duplicated or reordered.
  - Rewriting the same value does not flush.
- flush with in_valid=1 in the same cycle: the incoming item is dropped, not retained.
- flush and cfg_we in the same cycle: both apply.
- Stages beyond cur_delay keep shifting but are unobservable.
- out_value is raw stage data when out_valid=0. It is not forced to zero; benches compare it only when valid.
- Reset asserted mid-stream: immediate clear, all in-flight items lost. Deassertion is synchronised externally.

Optional Feature:
- Macro: DELAY_PIPE_OCC_EN.
- Defined:
  - occ = popcount of stage[1..cur_delay].valid; combinational, range 0..cur_delay.
  - occ = 0 when cur_delay = 0.
- Undefined: occ port and popcount logic are absent; all other behaviour is identical.

Decomposition:
- Package delay_pipe_pkg:
  - function clog2_dw(depth) for DW.
  - constant DELAY_PIPE_MAX_SUPPORTED = 64.
- Sub-module delay_pipe_stage: WIDTH+1-bit register with async active-high reset, enable (gwe) and valid-clear input.
  - Instantiated MAX_DEPTH times in a generate loop.
- Top level contains the cur_delay register, flush_eff logic, tap mux and optional popcount.

Test Plan:
- Reset with defaults (WIDTH=16, MAX_DEPTH=8, RESET_DELAY=8) -> cur_delay=8, out_valid=0, out_value=0, occ=0.
- Stream values 1..20 with in_valid=1, gwe=1 from cycle 0 -> out_value=1 with out_valid at cycle 8, then consecutive values through 20 at cycle 27; occ reaches 8.
- Same stream with gwe=0 during cycles 4-6 -> outputs frozen during the stall; value 1 appears at cycle 11; no loss, no duplication.
- Mid-stream cfg_we=1, cfg_delay=3 -> all valid bits cleared, cur_delay=3; next input (value 0x00AA) appears valid exactly 3 cycles later.
- cfg_delay=0, then cfg_delay=15 -> first: out_value equals in_value in the same cycle; second: cur_delay saturates to 8 with implicit flush.
- flush=1 together with in_valid=1 (value 0x1234) while 5 items are in flight -> none of the 6 items is ever output with out_valid=1; occ=0 next cycle.
- Async rst pulse between clock edges mid-stream -> outputs clear immediately, without waiting for a clock edge.
